oam_dma: RTL
============

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter: N_BYTES, 160, number of bytes copied per transfer.
REQ-002 Parameter: OAM_BASE, 16'hFE00, first destination address in OAM.
REQ-003 Port: clock  input  1  sole clock; all state updates on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse issued by the register decoder on a CPU write to FF46.
REQ-006 Port: src_hi  input  8  the byte written to FF46; source page high byte.
REQ-007 Port: A_src  output  16  source read address toward the MMU.
REQ-008 Port: rd_src  output  1  source read strobe.
REQ-009 Port: Di_src  input  8  source read data, valid the cycle after rd_src is high.
REQ-010 Port: A_oam  output  16  OAM write address.
REQ-011 Port: Do_oam  output  8  OAM write data.
REQ-012 Port: wr_oam  output  1  OAM write strobe.
REQ-013 Port: busy  output  1  transfer in progress; the MMU blocks CPU access outside HRAM, and the PPU OAM mux yields OAM to this block.
REQ-014 Port: done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-015 The block SHALL have states IDLE, READ and WRITE, held in a state register, plus an 8-bit byte index idx and an 8-bit latched page register src.
REQ-016 start sampled high in any state SHALL latch src, set idx to 0 and make the next state READ; start has priority over every other transition except reset.
REQ-017 src latch rule: if src_hi >= 8'hE0, store src_hi - 8'h20 (echo mirror; for example F1 is stored as D1); otherwise store src_hi unchanged.
REQ-018 READ: A_src = {src, idx}; rd_src = 1; wr_oam = 0; next state is WRITE.
REQ-019 WRITE: A_oam = OAM_BASE + idx; Do_oam = Di_src, passed combinationally in that cycle; wr_oam = 1; rd_src = 0.
REQ-020 WRITE with idx == N_BYTES-1 and no start: next state is IDLE and done = 1 in the following cycle only.
REQ-021 WRITE with idx < N_BYTES-1 and no start: idx increments by 1 and the next state is READ.
REQ-022 Each byte SHALL take exactly 2 cycles, so a full transfer takes 320 cycles. busy SHALL be high in READ and WRITE and low in IDLE.
REQ-023 Timing: with start sampled at edge 0, the first READ occurs in cycle 1, the last WRITE in cycle 320, and done with busy low in cycle 321.
REQ-024 In IDLE, A_src, A_oam and Do_oam SHALL be 0, and rd_src, wr_oam and busy SHALL be 0.
REQ-025 start during READ: no write for that byte; the transfer restarts from idx 0 with the new src.
REQ-026 start during WRITE: the current write still occurs in that cycle; the next cycle is READ with idx 0 and the new src.
REQ-027 An aborted transfer SHALL NOT pulse done.
REQ-028 start sampled in the same cycle that done is high SHALL begin a new transfer with no gap cycle.
REQ-029 idx arithmetic is 8-bit; idx SHALL never exceed N_BYTES-1, and the OAM address never exceeds FE9F.
REQ-030 All outputs SHALL be decoded solely from registered state and idx, except Do_oam, which passes Di_src through.

Reset
REQ-031 reset SHALL force IDLE, idx = 0, src = 0 and done = 0 at the next posedge, overriding start.
REQ-032 reset mid-transfer SHALL suppress all further rd_src and wr_oam activity from the next cycle onward, with no done pulse.
REQ-033 After reset, all outputs SHALL match the IDLE values given in REQ-024.

Verification
REQ-034 Full copy: src_hi=C0; memory model returns data = addr[7:0]^A5 one cycle after rd_src -> 160 OAM writes FE00..FE9F, each with data idx^A5; done high in cycle 321 only; busy high for cycles 1-320.
REQ-035 Echo mirror: src_hi=F1 -> reads D100..D19F; src_hi=DF -> reads DF00..DF9F.
REQ-036 Restart: src_hi=C0 started; start again with src_hi=80 during a READ cycle (cycle 101) -> writes resume at FE00 with data from 8000; one done only, 320 cycles after the restart; no write occurs for the aborted byte.
REQ-037 Restart during WRITE: start in cycle 100 -> that write to FE31 still occurs; the next READ is at {new src,00}.
REQ-038 Reset at cycle 50 -> IDLE from cycle 51; no rd_src, wr_oam or done afterwards; busy = 0.
REQ-039 Back-to-back: a second start in the done cycle -> READ in the next cycle at idx 0, with busy low for only that one done cycle.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: copies N_BYTES from source page {src,00} into OAM, one read cycle and one write cycle per byte.
module oam_dma #(
    parameter int          N_BYTES  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  src_hi,
    output logic [15:0] A_src,
    output logic        rd_src,
    input  logic [7:0]  Di_src,
    output logic [15:0] A_oam,
    output logic [7:0]  Do_oam,
    output logic        wr_oam,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam logic [7:0] LAST = 8'(N_BYTES - 1);
    state_t     state, state_nxt;
    logic [7:0] idx, idx_nxt, src, src_nxt;
    logic       done_nxt;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 8'h00;
            src   <= 8'h00;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            src   <= src_nxt;
            done  <= done_nxt;
        end
    end
    // a new start always wins, so a restart never finishes the old transfer
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        src_nxt   = src;
        done_nxt  = 1'b0;
        if (start) begin
            state_nxt = READ;
            idx_nxt   = 8'h00;
            src_nxt   = src_hi >= 8'hE0 ? src_hi - 8'h20 : src_hi;
        end else if (state == READ) begin
            state_nxt = WRITE;
        end else if (state == WRITE) begin
            state_nxt = idx == LAST ? IDLE : READ;
            idx_nxt   = idx == LAST ? idx : idx + 8'h01;
            done_nxt  = idx == LAST;
        end
    end
    assign rd_src = state == READ;
    assign wr_oam = state == WRITE;
    assign busy   = state != IDLE;
    assign A_src  = rd_src ? {src, idx} : 16'h0000;
    assign A_oam  = wr_oam ? OAM_BASE + {8'h00, idx} : 16'h0000;
    assign Do_oam = wr_oam ? Di_src : 8'h00;
endmodule
